// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_pkg
// Description : Shared pipeline constants: control-bit layout, bubble value,
//               register-index width and the ID/EX slot action encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

    localparam int CTRL_W    = 8;
    localparam int REG_IDX_W = 5;

    // Bit positions inside the 8-bit control word
    localparam int CTRL_REGWRITE  = 7;
    localparam int CTRL_MEMREAD   = 6;
    localparam int CTRL_MEMWRITE  = 5;
    localparam int CTRL_MEMTOREG  = 4;
    localparam int CTRL_ALUSRC    = 3;
    localparam int CTRL_BRANCH    = 2;
    localparam int CTRL_ALUOP_MSB = 1;
    localparam int CTRL_ALUOP_LSB = 0;

    localparam logic [CTRL_W-1:0] BUBBLE_CTRL = 8'h00;

    typedef enum logic [1:0] {
        SLOT_CAPTURE = 2'd0,
        SLOT_FLUSH   = 2'd1,
        SLOT_STALL   = 2'd2,
        SLOT_IDLE    = 2'd3
    } slot_action_e;

endpackage
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detect
// Description : Combinational load-use hazard detection; a flush in EX
//               suppresses the stall since the ID instruction is killed.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect
    import pipeline_pkg::*;
(
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_uses_rs1,
    input  logic                 id_uses_rs2,
    input  logic                 id_ex_valid,
    input  logic [REG_IDX_W-1:0] id_ex_rd,
    input  logic                 id_ex_mem_read,
    input  logic                 ex_flush,
    output logic                 stall
);

    logic w_rs1_match;
    logic w_rs2_match;
    logic w_hz;

    assign w_rs1_match = id_uses_rs1 & (id_ex_rd == id_rs1);
    assign w_rs2_match = id_uses_rs2 & (id_ex_rd == id_rs2);

    // x0 is never a real destination, so a load into it cannot create a hazard
    assign w_hz = id_valid & id_ex_mem_read & id_ex_valid & (id_ex_rd != '0)
                & (w_rs1_match | w_rs2_match);

    assign stall = w_hz & ~ex_flush;

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register with load-use stall, branch flush
//               bubble insertion and stall/flush event counters.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage
    import pipeline_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 id_valid,
    input  logic [XLEN-1:0]      id_pc,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic [REG_IDX_W-1:0] id_rd,
    input  logic                 id_uses_rs1,
    input  logic                 id_uses_rs2,
    input  logic [XLEN-1:0]      id_rs1_data,
    input  logic [XLEN-1:0]      id_rs2_data,
    input  logic [XLEN-1:0]      id_imm,
    input  logic [CTRL_W-1:0]    id_ctrl,
    input  logic                 ex_flush,
    output logic                 id_ex_valid,
    output logic [XLEN-1:0]      id_ex_pc,
    output logic [XLEN-1:0]      id_ex_rs1_data,
    output logic [XLEN-1:0]      id_ex_rs2_data,
    output logic [XLEN-1:0]      id_ex_imm,
    output logic [REG_IDX_W-1:0] id_ex_rs1,
    output logic [REG_IDX_W-1:0] id_ex_rs2,
    output logic [REG_IDX_W-1:0] id_ex_rd,
    output logic [CTRL_W-1:0]    id_ex_ctrl,
    output logic                 stall,
    output logic [CNT_W-1:0]     stall_count,
    output logic [CNT_W-1:0]     flush_count
);

    logic                 r_valid;
    logic [XLEN-1:0]      r_pc;
    logic [XLEN-1:0]      r_rs1_data;
    logic [XLEN-1:0]      r_rs2_data;
    logic [XLEN-1:0]      r_imm;
    logic [REG_IDX_W-1:0] r_rs1;
    logic [REG_IDX_W-1:0] r_rs2;
    logic [REG_IDX_W-1:0] r_rd;
    logic [CTRL_W-1:0]    r_ctrl;
    logic [CNT_W-1:0]     r_stall_count;
    logic [CNT_W-1:0]     r_flush_count;

    logic                 w_stall;
    slot_action_e         w_action;

    hazard_detect u_hazard_detect (
        .id_valid       (id_valid),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_uses_rs1    (id_uses_rs1),
        .id_uses_rs2    (id_uses_rs2),
        .id_ex_valid    (r_valid),
        .id_ex_rd       (r_rd),
        .id_ex_mem_read (r_ctrl[CTRL_MEMREAD]),
        .ex_flush       (ex_flush),
        .stall          (w_stall)
    );

    // Flush outranks stall, which outranks an empty ID slot
    always_comb begin
        w_action = SLOT_CAPTURE;
        if (ex_flush)
            w_action = SLOT_FLUSH;
        else if (w_stall)
            w_action = SLOT_STALL;
        else if (!id_valid)
            w_action = SLOT_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid       <= 1'b0;
            r_pc          <= '0;
            r_rs1_data    <= '0;
            r_rs2_data    <= '0;
            r_imm         <= '0;
            r_rs1         <= '0;
            r_rs2         <= '0;
            r_rd          <= '0;
            r_ctrl        <= BUBBLE_CTRL;
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            // Every non-capture action loads a fully zeroed bubble
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_ctrl     <= BUBBLE_CTRL;
            case (w_action)
                SLOT_FLUSH: r_flush_count <= r_flush_count + CNT_W'(1);
                SLOT_STALL: r_stall_count <= r_stall_count + CNT_W'(1);
                SLOT_IDLE:  ;
                default: begin
                    r_valid    <= 1'b1;
                    r_pc       <= id_pc;
                    r_rs1_data <= id_rs1_data;
                    r_rs2_data <= id_rs2_data;
                    r_imm      <= id_imm;
                    r_rs1      <= id_rs1;
                    r_rs2      <= id_rs2;
                    r_rd       <= id_rd;
                    r_ctrl     <= id_ctrl;
                end
            endcase
        end
    end

    assign id_ex_valid    = r_valid;
    assign id_ex_pc       = r_pc;
    assign id_ex_rs1_data = r_rs1_data;
    assign id_ex_rs2_data = r_rs2_data;
    assign id_ex_imm      = r_imm;
    assign id_ex_rs1      = r_rs1;
    assign id_ex_rs2      = r_rs2;
    assign id_ex_rd       = r_rd;
    assign id_ex_ctrl     = r_ctrl;
    assign stall          = w_stall;
    assign stall_count    = r_stall_count;
    assign flush_count    = r_flush_count;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Self-checking bench for id_ex_stage against a behavioural
//               model of the EX slot and event counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            id_valid;
    logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]      id_rs1, id_rs2, id_rd;
    logic            id_uses_rs1, id_uses_rs2;
    logic [7:0]      id_ctrl;
    logic            ex_flush;
    logic            id_ex_valid;
    logic [XLEN-1:0] id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm;
    logic [4:0]      id_ex_rs1, id_ex_rs2, id_ex_rd;
    logic [7:0]      id_ex_ctrl;
    logic            stall;
    logic [CNT_W-1:0] stall_count, flush_count;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model of what the EX slot should contain
    logic            m_valid;
    logic [XLEN-1:0] m_pc, m_rs1_data, m_rs2_data, m_imm;
    logic [4:0]      m_rs1, m_rs2, m_rd;
    logic [7:0]      m_ctrl;
    int              m_sc, m_fc;

    localparam logic [7:0] LW_CTRL  = 8'hD0;
    localparam logic [7:0] ADD_CTRL = 8'h82;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_ctrl(id_ctrl), .ex_flush(ex_flush), .id_ex_valid(id_ex_valid),
        .id_ex_pc(id_ex_pc), .id_ex_rs1_data(id_ex_rs1_data),
        .id_ex_rs2_data(id_ex_rs2_data), .id_ex_imm(id_ex_imm),
        .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd),
        .id_ex_ctrl(id_ex_ctrl), .stall(stall),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    // A load sits in EX writing a real register that the ID instruction reads
    function automatic logic exp_stall();
        logic ex_is_load;
        logic reads_it;
        ex_is_load = m_valid && m_ctrl[6] && (m_rd != 5'd0);
        reads_it   = (id_uses_rs1 && id_rs1 == m_rd) || (id_uses_rs2 && id_rs2 == m_rd);
        return id_valid && ex_is_load && reads_it && !ex_flush;
    endfunction

    task automatic model_empty_slot();
        m_valid = 1'b0; m_pc = '0; m_rs1_data = '0; m_rs2_data = '0; m_imm = '0;
        m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_ctrl = '0;
    endtask

    task automatic model_reset();
        model_empty_slot();
        m_sc = 0; m_fc = 0;
    endtask

    task automatic model_edge();
        if (ex_flush) begin
            model_empty_slot();
            m_fc = (m_fc + 1) % (1 << CNT_W);
        end else if (exp_stall()) begin
            model_empty_slot();
            m_sc = (m_sc + 1) % (1 << CNT_W);
        end else if (!id_valid) begin
            model_empty_slot();
        end else begin
            m_valid = 1'b1; m_pc = id_pc; m_rs1_data = id_rs1_data;
            m_rs2_data = id_rs2_data; m_imm = id_imm;
            m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd; m_ctrl = id_ctrl;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [XLEN-1:0] pc,
                          input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic u1, input logic u2,
                          input logic [7:0] ctrl, input logic fl);
        id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_uses_rs1 = u1; id_uses_rs2 = u2; id_ctrl = ctrl; ex_flush = fl;
        id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
    endtask

    task automatic sync_reset();
        @(negedge clk);
        reset = 1'b1;
        set_id(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One load into rd=5 followed by a dependent add -> one stall
    task automatic one_stall_event();
        @(negedge clk);
        set_id(1'b1, 32'h200, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, LW_CTRL, 1'b0);
        tick();
        @(negedge clk);
        set_id(1'b1, 32'h204, 5'd5, 5'd2, 5'd6, 1'b1, 1'b1, ADD_CTRL, 1'b0);
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_id(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({id_ex_valid, id_ex_ctrl, id_ex_pc, id_ex_rd} !== '0) begin
            n_fail++;
            $display("FAIL reset_slot: got valid=%0b ctrl=%h pc=%h rd=%0d, need all 0",
                     id_ex_valid, id_ex_ctrl, id_ex_pc, id_ex_rd);
        end
        n_cmp++;
        if (stall_count !== '0 || flush_count !== '0 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_counters: got sc=%0d fc=%0d stall=%0b, need 0 0 0",
                     stall_count, flush_count, stall);
        end
        reset = 1'b0;
    endtask

    task automatic test_normal_capture();
        @(negedge clk);
        set_id(1'b1, 32'h100, 5'd3, 5'd4, 5'd5, 1'b1, 1'b1, 8'h80, 1'b0);
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL capture_stall: got %0b need 0", stall);
        end
        tick();
        n_cmp++;
        if (id_ex_pc !== 32'h100 || id_ex_rd !== 5'd5 || id_ex_ctrl !== 8'h80 ||
            id_ex_valid !== 1'b1 || id_ex_rs1_data !== m_rs1_data) begin
            n_fail++;
            $display("FAIL capture_fields: got pc=%h rd=%0d ctrl=%h valid=%0b rs1d=%h need 100 5 80 1 %h",
                     id_ex_pc, id_ex_rd, id_ex_ctrl, id_ex_valid, id_ex_rs1_data, m_rs1_data);
        end
    endtask

    task automatic test_load_use();
        @(negedge clk);
        set_id(1'b1, 32'h104, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, LW_CTRL, 1'b0);
        tick();
        @(negedge clk);
        set_id(1'b1, 32'h108, 5'd5, 5'd6, 5'd7, 1'b1, 1'b1, ADD_CTRL, 1'b0);
        #1;
        n_cmp++;
        if (stall !== 1'b1) begin
            n_fail++; $display("FAIL loaduse_stall: got %0b need 1", stall);
        end
        tick();
        n_cmp++;
        if (id_ex_ctrl !== 8'h00 || id_ex_valid !== 1'b0 || stall_count !== CNT_W'(1)) begin
            n_fail++;
            $display("FAIL loaduse_bubble: got ctrl=%h valid=%0b sc=%0d need 00 0 1",
                     id_ex_ctrl, id_ex_valid, stall_count);
        end
        n_cmp++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL loaduse_release: got stall=%0b need 0", stall);
        end
        tick();
        n_cmp++;
        if (id_ex_valid !== 1'b1 || id_ex_pc !== 32'h108 || id_ex_ctrl !== ADD_CTRL) begin
            n_fail++;
            $display("FAIL loaduse_capture: got valid=%0b pc=%h ctrl=%h need 1 108 82",
                     id_ex_valid, id_ex_pc, id_ex_ctrl);
        end
    endtask

    task automatic test_no_false_stall();
        @(negedge clk);
        set_id(1'b1, 32'h120, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, LW_CTRL, 1'b0);
        tick();
        @(negedge clk);
        set_id(1'b1, 32'h124, 5'd9, 5'd5, 5'd7, 1'b1, 1'b0, ADD_CTRL, 1'b0);
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL nostall_unused_rs2: got %0b need 0", stall);
        end
        tick();
        @(negedge clk);
        set_id(1'b1, 32'h128, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, LW_CTRL, 1'b0);
        tick();
        @(negedge clk);
        set_id(1'b1, 32'h12C, 5'd0, 5'd3, 5'd7, 1'b1, 1'b1, ADD_CTRL, 1'b0);
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL nostall_rd_x0: got %0b need 0", stall);
        end
        tick();
    endtask

    task automatic test_flush_priority();
        int sc_before;
        @(negedge clk);
        set_id(1'b1, 32'h140, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, LW_CTRL, 1'b0);
        tick();
        sc_before = m_sc;
        @(negedge clk);
        set_id(1'b1, 32'h144, 5'd5, 5'd5, 5'd7, 1'b1, 1'b1, ADD_CTRL, 1'b1);
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL flush_stall: got %0b need 0", stall);
        end
        tick();
        n_cmp++;
        if (id_ex_valid !== 1'b0 || id_ex_ctrl !== 8'h00 || flush_count !== CNT_W'(1) ||
            stall_count !== CNT_W'(sc_before)) begin
            n_fail++;
            $display("FAIL flush_bubble: got valid=%0b ctrl=%h fc=%0d sc=%0d need 0 00 1 %0d",
                     id_ex_valid, id_ex_ctrl, flush_count, stall_count, sc_before);
        end
        ex_flush = 1'b0;
    endtask

    task automatic test_async_reset();
        sync_reset();
        repeat (7) one_stall_event();
        @(negedge clk);
        set_id(1'b1, 32'h300, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, LW_CTRL, 1'b0);
        tick();
        n_cmp++;
        if (stall_count !== CNT_W'(7) || id_ex_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_setup: got sc=%0d valid=%0b need 7 1", stall_count, id_ex_valid);
        end
        @(negedge clk);
        set_id(1'b1, 32'h304, 5'd5, 5'd2, 5'd6, 1'b1, 1'b0, ADD_CTRL, 1'b0);
        #1;
        n_cmp++;
        if (stall !== 1'b1) begin
            n_fail++; $display("FAIL areset_prestall: got %0b need 1", stall);
        end
        #1 reset = 1'b1;
        #1;
        model_reset();
        n_cmp++;
        if ({id_ex_valid, id_ex_ctrl, id_ex_pc, id_ex_rd, stall_count, flush_count, stall} !== '0) begin
            n_fail++;
            $display("FAIL areset_clear: got valid=%0b ctrl=%h pc=%h rd=%0d sc=%0d fc=%0d stall=%0b need all 0",
                     id_ex_valid, id_ex_ctrl, id_ex_pc, id_ex_rd, stall_count, flush_count, stall);
        end
        @(negedge clk);
        reset = 1'b0;
        tick();
        n_cmp++;
        if (id_ex_valid !== 1'b1 || id_ex_pc !== 32'h304 || stall_count !== '0) begin
            n_fail++;
            $display("FAIL areset_first_edge: got valid=%0b pc=%h sc=%0d need 1 304 0",
                     id_ex_valid, id_ex_pc, stall_count);
        end
    endtask

    task automatic test_counter_wrap();
        sync_reset();
        repeat (15) one_stall_event();
        n_cmp++;
        if (stall_count !== CNT_W'(15)) begin
            n_fail++; $display("FAIL wrap_15: got sc=%0d need 15", stall_count);
        end
        one_stall_event();
        n_cmp++;
        if (stall_count !== '0) begin
            n_fail++; $display("FAIL wrap_16: got sc=%0d need 0", stall_count);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            set_id(($urandom_range(7, 0) != 0), $urandom,
                   5'($urandom_range(3, 0)), 5'($urandom_range(3, 0)),
                   5'($urandom_range(3, 0)), 1'($urandom), 1'($urandom),
                   8'($urandom) | ($urandom_range(1, 0) != 0 ? 8'h40 : 8'h00),
                   ($urandom_range(7, 0) == 0));
            #1;
            n_cmp++;
            if (stall !== exp_stall()) begin
                n_fail++; $display("FAIL rand_stall[%0d]: got %0b need %0b", i, stall, exp_stall());
            end
            tick();
            n_cmp++;
            if ({id_ex_valid, id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm,
                 id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_ctrl, stall_count, flush_count} !==
                {m_valid, m_pc, m_rs1_data, m_rs2_data, m_imm, m_rs1, m_rs2, m_rd, m_ctrl,
                 CNT_W'(m_sc), CNT_W'(m_fc)}) begin
                n_fail++;
                $display("FAIL rand_slot[%0d]: got v=%0b pc=%h rd=%0d ctrl=%h sc=%0d fc=%0d need v=%0b pc=%h rd=%0d ctrl=%h sc=%0d fc=%0d",
                         i, id_ex_valid, id_ex_pc, id_ex_rd, id_ex_ctrl, stall_count, flush_count,
                         m_valid, m_pc, m_rd, m_ctrl, m_sc, m_fc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_normal_capture();
        test_load_use();
        test_no_false_stall();
        test_flush_priority();
        test_async_reset();
        test_counter_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
